psram_arbiter: RTL and testbench

//  Shares the single word-based PsramController between NPORT requesters (e.g. video fetch, CPU, DMA).

---
 rtl/psram_pkg.sv | 26 ++
 rtl/psram_arbiter_if.sv | 46 ++++
 rtl/psram_arb_pick.sv | 34 +++
 rtl/psram_arbiter.sv | 147 ++++++++++++++
 tb/tb_psram_arbiter.sv | 263 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/psram_pkg.sv
// Shared types and constants for the PSRAM requester arbiter.
// Holds the FSM encoding, bus widths and a port-wrap helper.
package psram_pkg;

  localparam int PSRAM_ADDR_W = 22;
  localparam int PSRAM_DATA_W = 16;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    DONE
  } arb_state_e;

  // (base + off) mod n, for base < n and off < n
  function automatic int port_wrap(
    input int base,
    input int off,
    input int n
  );
    int s;
    s = base + off;
    return (s >= n) ? s - n : s;
  endfunction

endpackage

// File: rtl/psram_arbiter_if.sv
// Bundle between requesters / controller and the PSRAM arbiter.
// slave: arbiter view; master: requester + controller view.
interface psram_arbiter_if
  import psram_pkg::*;
#(
  parameter int NPORT  = 3,
  parameter int ADDR_W = PSRAM_ADDR_W,
  parameter int DATA_W = PSRAM_DATA_W
);

  localparam int IDW = (NPORT > 1) ? $clog2(NPORT) : 1;

  logic [NPORT-1:0]        req;
  logic [NPORT-1:0]        we;
  logic [NPORT-1:0]        byte_we;
  logic [NPORT*ADDR_W-1:0] addr;
  logic [NPORT*DATA_W-1:0] wdata;
  logic [NPORT-1:0]        ack;
  logic [DATA_W-1:0]       rdata;
  logic [IDW-1:0]          grant_id;

  logic                    mem_read;
  logic                    mem_write;
  logic [ADDR_W-1:0]       mem_addr;
  logic [DATA_W-1:0]       mem_din;
  logic                    mem_byte_write;
  logic [DATA_W-1:0]       mem_dout;
  logic                    mem_busy;

  modport slave (
    input  req, we, byte_we, addr, wdata,
    input  mem_dout, mem_busy,
    output ack, rdata, grant_id,
    output mem_read, mem_write, mem_addr,
    output mem_din, mem_byte_write
  );

  modport master (
    output req, we, byte_we, addr, wdata,
    output mem_dout, mem_busy,
    input  ack, rdata, grant_id,
    input  mem_read, mem_write, mem_addr,
    input  mem_din, mem_byte_write
  );

endinterface

// File: rtl/psram_arb_pick.sv
// Combinational winner select: first pending req at or after start.
// Ports: req, start in; any, onehot, idx out.
module psram_arb_pick
  import psram_pkg::*;
#(
  parameter int NPORT = 3,
  parameter int IDW   = 2
) (
  input  logic [NPORT-1:0] req,
  input  logic [IDW-1:0]   start,
  output logic             any,
  output logic [NPORT-1:0] onehot,
  output logic [IDW-1:0]   idx
);

  int p;

  // Scan from farthest to nearest so the nearest hit is written last.
  always_comb begin
    any    = |req;
    onehot = '0;
    idx    = '0;
    p      = 0;
    for (int i = NPORT - 1; i >= 0; i--) begin
      p = port_wrap(int'(start), i, NPORT);
      if (req[p]) begin
        onehot    = '0;
        onehot[p] = 1'b1;
        idx       = IDW'(p);
      end
    end
  end

endmodule

// File: rtl/psram_arbiter.sv
// Shares one PSRAM controller among NPORT requesters.
// Ports: clk, reset (async, active-high), bus (psram_arbiter_if.slave).
// Define PSRAM_ARB_RR_EN for round-robin; default is fixed priority.
module psram_arbiter
  import psram_pkg::*;
#(
  parameter int NPORT  = 3,
  parameter int ADDR_W = PSRAM_ADDR_W,
  parameter int DATA_W = PSRAM_DATA_W
) (
  input logic            clk,
  input logic            reset,
  psram_arbiter_if.slave bus
);

  localparam int IDW = (NPORT > 1) ? $clog2(NPORT) : 1;

  arb_state_e        state_q, state_d;
  logic              grant;
  logic              any_req;
  logic [NPORT-1:0]  win_oh;
  logic [IDW-1:0]    win_idx;
  logic [IDW-1:0]    start;

  logic              sel_we, sel_bw;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_din;

  logic              we_q, bw_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] din_q;
  logic [NPORT-1:0]  oh_q;
  logic [IDW-1:0]    gid_q;
  logic [NPORT-1:0]  ack_q;
  logic [DATA_W-1:0] rdata_q;
  logic              rd, wr;

  // No grant while the controller is busy (incl. its init phase).
  assign grant = (state_q == IDLE) && any_req && !bus.mem_busy;

`ifdef PSRAM_ARB_RR_EN
  logic [IDW-1:0] ptr_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ptr_q <= '0;
    end else if (grant) begin
      ptr_q <= (win_idx == IDW'(NPORT - 1)) ? '0
             : win_idx + IDW'(1);
    end
  end

  assign start = ptr_q;
`else
  assign start = '0;
`endif

  psram_arb_pick #(
    .NPORT (NPORT),
    .IDW   (IDW)
  ) u_pick (
    .req    (bus.req),
    .start  (start),
    .any    (any_req),
    .onehot (win_oh),
    .idx    (win_idx)
  );

  always_comb begin
    sel_we   = 1'b0;
    sel_bw   = 1'b0;
    sel_addr = '0;
    sel_din  = '0;
    for (int i = 0; i < NPORT; i++) begin
      if (win_oh[i]) begin
        sel_we   = bus.we[i];
        sel_bw   = bus.byte_we[i];
        sel_addr = bus.addr[i*ADDR_W +: ADDR_W];
        sel_din  = bus.wdata[i*DATA_W +: DATA_W];
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    rd      = 1'b0;
    wr      = 1'b0;
    unique case (state_q)
      IDLE:  if (grant) state_d = ISSUE;
      ISSUE: begin
        rd      = ~we_q;
        wr      = we_q;
        state_d = WAIT;
      end
      WAIT:  if (!bus.mem_busy) state_d = DONE;
      DONE:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Command fields stay frozen until the next grant: the controller
  // still consumes byte_write after it drops the command strobe.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      we_q    <= 1'b0;
      bw_q    <= 1'b0;
      addr_q  <= '0;
      din_q   <= '0;
      oh_q    <= '0;
      gid_q   <= '0;
      ack_q   <= '0;
      rdata_q <= '0;
    end else begin
      ack_q <= '0;
      if (grant) begin
        we_q   <= sel_we;
        bw_q   <= sel_bw;
        addr_q <= sel_addr;
        din_q  <= sel_din;
        oh_q   <= win_oh;
        gid_q  <= win_idx;
      end
      if (state_q == WAIT && !bus.mem_busy) begin
        ack_q <= oh_q;
        if (!we_q) rdata_q <= bus.mem_dout;
      end
    end
  end

  assign bus.mem_read       = rd;
  assign bus.mem_write      = wr;
  assign bus.mem_addr       = addr_q;
  assign bus.mem_din        = din_q;
  assign bus.mem_byte_write = bw_q;
  assign bus.ack            = ack_q;
  assign bus.rdata          = rdata_q;
  assign bus.grant_id       = gid_q;

endmodule

// File: tb/tb_psram_arbiter.sv
// Scoreboard bench for psram_arbiter with a behavioural controller.
// Expected issues/acks are queued by stimulus and checked by a monitor.
module tb_psram_arbiter;
  import psram_pkg::*;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  psram_arbiter_if #(
    .NPORT (3),
    .ADDR_W(22),
    .DATA_W(16)
  ) bus ();

  psram_arbiter dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  typedef struct packed {
    logic [2:0]  ack;
    logic [15:0] rdata;
  } ack_exp_t;

  typedef struct packed {
    logic        wr;
    logic        bw;
    logic [21:0] addr;
    logic [15:0] din;
  } iss_exp_t;

  int       n_cmp = 0;
  int       n_err = 0;
  ack_exp_t ack_q[$];
  iss_exp_t iss_q[$];
  iss_exp_t last_iss;
  iss_exp_t ie;
  ack_exp_t ae;
  logic     aborted = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic miss(input string nm);
    n_cmp++;
    n_err++;
    $display("FAIL %s: got none expected event", nm);
  endtask

  function automatic logic [31:0] oh2idx(input logic [2:0] oh);
    return oh[2] ? 32'd2 : oh[1] ? 32'd1 : 32'd0;
  endfunction

  // Behavioural controller: busy 1 cycle after a command, 10-15 long.
  int          init_left = 200;
  int          busy_left = 0;
  int          ops = 0;
  logic        rd_pend = 1'b0;
  logic [15:0] rd_val = '0;

  function automatic logic [15:0] mem_val(input logic [21:0] a);
    return (a == 22'h000124) ? 16'hBEEF : (a[15:0] ^ 16'h5A5A);
  endfunction

  always @(posedge clk) begin
    if (init_left > 0) begin
      init_left    <= init_left - 1;
      bus.mem_busy <= (init_left > 1);
      bus.mem_dout <= '0;
    end else if (busy_left > 0) begin
      busy_left <= busy_left - 1;
      if (busy_left == 1) begin
        bus.mem_busy <= 1'b0;
        if (rd_pend) bus.mem_dout <= rd_val;
      end
    end else if (bus.mem_read || bus.mem_write) begin
      bus.mem_busy <= 1'b1;
      busy_left    <= 10 + (ops % 6);
      ops          <= ops + 1;
      rd_pend      <= bus.mem_read;
      rd_val       <= mem_val(bus.mem_addr);
    end
  end

  always @(negedge clk) begin
    if (bus.mem_read || bus.mem_write) begin
      chk("issue_when_ready", 32'(init_left == 0 && busy_left == 0), 32'd1);
      if (iss_q.size() == 0) begin
        miss("unexpected_issue");
      end else begin
        ie = iss_q.pop_front();
        chk("issue_rw", 32'({bus.mem_read, bus.mem_write}),
            32'({~ie.wr, ie.wr}));
        chk("issue_addr", 32'(bus.mem_addr), 32'(ie.addr));
        if (ie.wr) begin
          chk("issue_din", 32'(bus.mem_din), 32'(ie.din));
          chk("issue_bw", 32'(bus.mem_byte_write), 32'(ie.bw));
        end
        last_iss = ie;
        aborted  = 1'b0;
      end
    end
    if (bus.mem_busy && busy_left == 1 && init_left == 0 && !aborted) begin
      chk("hold_addr", 32'(bus.mem_addr), 32'(last_iss.addr));
      chk("hold_bw", 32'(bus.mem_byte_write), 32'(last_iss.bw));
    end
    if (bus.ack != '0) begin
      chk("ack_onehot", 32'($countones(bus.ack)), 32'd1);
      if (ack_q.size() == 0) begin
        miss("unexpected_ack");
      end else begin
        ae = ack_q.pop_front();
        chk("ack_port", 32'(bus.ack), 32'(ae.ack));
        chk("ack_rdata", 32'(bus.rdata), 32'(ae.rdata));
        chk("grant_id", 32'(bus.grant_id), oh2idx(ae.ack));
      end
    end
  end

  task automatic drive(input int p, input logic w, input logic bw,
                       input logic [21:0] a, input logic [15:0] d);
    bus.we[p]            = w;
    bus.byte_we[p]       = bw;
    bus.addr[p*22 +: 22] = a;
    bus.wdata[p*16 +: 16] = d;
    bus.req[p]           = 1'b1;
  endtask

  task automatic wait_ack(input int p, input int budget);
    bit got;
    got = 1'b0;
    for (int i = 0; i < budget && !got; i++) begin
      @(negedge clk);
      if (bus.ack[p]) got = 1'b1;
    end
    if (!got) miss("ack_timeout");
    bus.req[p] = 1'b0;
  endtask

  task automatic wait_any(input int budget);
    bit got;
    got = 1'b0;
    for (int i = 0; i < budget && !got; i++) begin
      @(negedge clk);
      if (bus.ack != '0) got = 1'b1;
    end
    if (!got) miss("ack_timeout");
  endtask

  task automatic wait_busy(input int budget);
    bit got;
    got = 1'b0;
    for (int i = 0; i < budget && !got; i++) begin
      @(negedge clk);
      if (bus.mem_busy) got = 1'b1;
    end
    if (!got) miss("busy_timeout");
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1);
  end

  initial begin
    bus.req     = '0;
    bus.we      = '0;
    bus.byte_we = '0;
    bus.addr    = '0;
    bus.wdata   = '0;
    repeat (3) @(negedge clk);
    chk("reset_ctl", 32'({bus.ack, bus.mem_read, bus.mem_write,
        bus.mem_byte_write, bus.grant_id}), 32'd0);
    chk("reset_rdata", 32'(bus.rdata), 32'd0);
    chk("reset_addr", 32'(bus.mem_addr), 32'd0);
    reset = 1'b0;

    // Init: request held while controller initialises.
    iss_q.push_back('{1'b0, 1'b0, 22'h000010, 16'h0});
    ack_q.push_back('{3'b001, 16'h5A4A});
    drive(0, 1'b0, 1'b0, 22'h000010, 16'h0);
    wait_ack(0, 400);

    // Single read on port 1.
    iss_q.push_back('{1'b0, 1'b0, 22'h000124, 16'h0});
    ack_q.push_back('{3'b010, 16'hBEEF});
    drive(1, 1'b0, 1'b0, 22'h000124, 16'h0);
    wait_ack(1, 60);

    // Byte write on port 2; rdata must keep the last read word.
    iss_q.push_back('{1'b1, 1'b1, 22'h000011, 16'hA500});
    ack_q.push_back('{3'b100, 16'hBEEF});
    drive(2, 1'b1, 1'b1, 22'h000011, 16'hA500);
    wait_ack(2, 60);
    bus.we[2]      = 1'b0;
    bus.byte_we[2] = 1'b0;

    // Port 0 drops req while its op is in flight.
    iss_q.push_back('{1'b0, 1'b0, 22'h000020, 16'h0});
    ack_q.push_back('{3'b001, 16'h5A7A});
    drive(0, 1'b0, 1'b0, 22'h000020, 16'h0);
    wait_busy(60);
    bus.req[0] = 1'b0;
    wait_ack(0, 60);
    repeat (25) @(negedge clk);
    chk("no_reissue", 32'(ops), 32'd4);

    // Reset during WAIT: op abandoned, no ack.
    iss_q.push_back('{1'b0, 1'b0, 22'h000030, 16'h0});
    drive(1, 1'b0, 1'b0, 22'h000030, 16'h0);
    wait_busy(60);
    repeat (3) @(negedge clk);
    aborted = 1'b1;
    #2 reset = 1'b1;
    #1;
    chk("rst_mid_ctl", 32'({bus.ack, bus.mem_read, bus.mem_write,
        bus.mem_byte_write, bus.grant_id}), 32'd0);
    chk("rst_mid_rdata", 32'(bus.rdata), 32'd0);
    chk("rst_mid_addr", 32'(bus.mem_addr), 32'd0);
    bus.req[1] = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;

    // Contention: all three ports held high for three transactions.
`ifdef PSRAM_ARB_RR_EN
    iss_q.push_back('{1'b0, 1'b0, 22'h000200, 16'h0});
    iss_q.push_back('{1'b0, 1'b0, 22'h000302, 16'h0});
    iss_q.push_back('{1'b0, 1'b0, 22'h000404, 16'h0});
    ack_q.push_back('{3'b001, 16'h585A});
    ack_q.push_back('{3'b010, 16'h5958});
    ack_q.push_back('{3'b100, 16'h5E5E});
`else
    for (int k = 0; k < 3; k++) begin
      iss_q.push_back('{1'b0, 1'b0, 22'h000200, 16'h0});
      ack_q.push_back('{3'b001, 16'h585A});
    end
`endif
    drive(0, 1'b0, 1'b0, 22'h000200, 16'h0);
    drive(1, 1'b0, 1'b0, 22'h000302, 16'h0);
    drive(2, 1'b0, 1'b0, 22'h000404, 16'h0);
    for (int k = 0; k < 3; k++) wait_any(100);
    bus.req = '0;

    repeat (30) @(negedge clk);
    chk("ack_q_empty", 32'(ack_q.size()), 32'd0);
    chk("iss_q_empty", 32'(iss_q.size()), 32'd0);
    chk("total_ops", 32'(ops), 32'd8);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
